button_led_ctrl: RTL and testbench
==================================

BUTTON_LED_CTRL -- requirements
Module: button_led_ctrl

Interface
REQ-001 SHALL have parameter LED_W, default 16, meaning LED count and value-register width (2..32).
REQ-002 SHALL have parameter DB_CYCLES, default 6250000, meaning the consecutive stable cycles required to accept a button level.
REQ-003 SHALL have parameter RPT_DELAY, default 50000000, meaning held cycles after the first step before auto-repeat starts; 0 disables auto-repeat.
REQ-004 SHALL have parameter RPT_PERIOD, default 12500000, meaning cycles between auto-repeat steps (>=1).
REQ-005 SHALL have port i_clk, input, 1, the single clock.
REQ-006 SHALL have port i_rst_n, input, 1, the reset; asynchronous, active-low.
REQ-007 SHALL have port i_btn_up, input, 1, the raw asynchronous increment button, active-high.
REQ-008 SHALL have port i_btn_dn, input, 1, the raw asynchronous decrement button, active-high.
REQ-009 SHALL have port i_btn_clr, input, 1, the raw asynchronous clear button, active-high.
REQ-010 SHALL have port i_mode, input, 2: bit0 selects wrap (0) or saturate (1); bit1 selects binary (0) or bar (1) display.
REQ-011 SHALL have port o_leds, output, LED_W, the LED drive.
REQ-012 SHALL have port o_value, output, LED_W, the current value register.
REQ-013 SHALL have port o_step, output, 1, a one-cycle pulse on every cycle the value register changes.

Function
REQ-014 Each button path SHALL pass through a 2-flop synchroniser before any other logic.
REQ-015 Each debouncer SHALL hold a debounced level and a counter; the counter clears whenever the synchronised input equals the debounced level, otherwise it increments; on reaching DB_CYCLES-1 the debounced level flips and the counter clears.
REQ-016 Glitches shorter than DB_CYCLES cycles SHALL never change a debounced level.
REQ-017 The up and dn paths SHALL each run a repeat FSM with states IDLE, DELAY and REPEAT.
REQ-018 In IDLE, a debounced rise SHALL emit one step request and move to DELAY with the timer cleared.
REQ-019 In DELAY, after RPT_DELAY held cycles the FSM SHALL emit a request and move to REPEAT; with RPT_DELAY=0 it SHALL stay in DELAY with no further requests.
REQ-020 In REPEAT, the FSM SHALL emit a request every RPT_PERIOD cycles.
REQ-021 A debounced fall SHALL return the FSM to IDLE from any state, with no request that cycle.
REQ-022 The clr path SHALL emit a single request on the debounced rise only, with no repeat.
REQ-023 Request priority SHALL be: clr sets value to 0; otherwise up and dn in the same cycle cancel with no change; otherwise up adds 1 or dn subtracts 1.
REQ-024 In wrap mode, max+1 SHALL give 0 and 0-1 SHALL give 2^LED_W-1.
REQ-025 In saturate mode, the value SHALL hold at 2^LED_W-1 or 0, and o_step SHALL stay low when the value does not change.
REQ-026 The value register SHALL update one cycle after a request; o_step SHALL be high in that same update cycle.
REQ-027 o_leds SHALL be registered; binary mode gives o_leds = value; bar mode gives the lowest min(value, LED_W) bits set.
REQ-028 o_leds SHALL lag the value register by one cycle, and a mode change SHALL affect o_leds one cycle later with the value unchanged.
REQ-029 End-to-end latency from the first i_clk edge sampling a stable press to the o_leds change SHALL be DB_CYCLES+4 cycles.

Reset
REQ-030 While i_rst_n=0, the synchronisers, debounced levels, counters, FSMs (IDLE), value, o_leds, o_value and o_step SHALL all be 0, asynchronously.
REQ-031 Reset deassertion SHALL be synchronised internally; the first update SHALL occur no earlier than 2 cycles after deassertion.
REQ-032 Reset during a held button SHALL require a fresh debounce, then give one step (FSM restarts in IDLE).

Verification (LED_W=4, DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3)
REQ-033 Hold up for 3 cycles then release -> no o_step; o_value stays 0.
REQ-034 Press up for 8 cycles -> exactly one o_step; o_value=1; o_leds=0001 at DB_CYCLES+4 cycles after the first sampling edge.
REQ-035 Hold up for 30 cycles after debounce -> steps at t0, t0+10, t0+13, t0+16, ... o_value=1,2,3,4, ...; stops within 1 cycle of the debounced fall.
REQ-036 With value=15: up in wrap mode -> 0 with o_step; up in saturate mode -> 15 with no o_step; value=0 plus dn in saturate -> stays 0.
REQ-037 Simultaneous debounced up+dn rises -> no change and no o_step; clr+up together -> o_value=0.
REQ-038 Set value=6 then mode=bar -> o_leds=0000_0000_0011_1111 scaled to 4 bits = 1111; value=2 in bar mode -> 0011; i_rst_n low mid-repeat -> all outputs 0 immediately.

Source files
------------

// File: rtl/button_led_ctrl.sv
// button_led_ctrl: debounced up/down/clear buttons with auto-repeat driving a
// wrap/saturate value register shown on LEDs as binary or bar graph.
module button_led_ctrl #(
  parameter int LED_W      = 16,
  parameter int DB_CYCLES  = 6250000,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 12500000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btn_up,
  input  logic             i_btn_dn,
  input  logic             i_btn_clr,
  input  logic [1:0]       i_mode,
  output logic [LED_W-1:0] o_leds,
  output logic [LED_W-1:0] o_value,
  output logic             o_step
);
  localparam int DW   = $clog2(DB_CYCLES + 1);
  localparam int TMAX = RPT_DELAY > RPT_PERIOD ? RPT_DELAY : RPT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_t;
  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [2:0]       raw, db, db_q, rise;
  logic [1:0]       fall, rpt_req;
  logic             clr_req;
  logic [LED_W-1:0] value, value_nx, bar;
  assign raw     = {i_btn_clr, i_btn_dn, i_btn_up};
  assign rst_n   = rst_sync[1];
  assign rise    = db & ~db_q;
  assign fall    = ~db[1:0] & db_q[1:0];
  assign o_value = value;
  // assertion is immediate, release waits two clock edges
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  for (genvar b = 0; b < 3; b++) begin : g_db
    logic [1:0]    sync;
    logic [DW-1:0] cnt;
    logic          lvl, lvl_q;
    always_ff @(posedge i_clk or negedge rst_n)
      if (!rst_n) begin
        sync  <= '0;
        cnt   <= '0;
        lvl   <= 1'b0;
        lvl_q <= 1'b0;
      end else begin
        sync  <= {sync[0], raw[b]};
        lvl_q <= lvl;
        if (sync[1] == lvl) cnt <= '0;
        else if (cnt == DW'(DB_CYCLES - 1)) begin
          cnt <= '0;
          lvl <= ~lvl;
        end else cnt <= cnt + DW'(1);
      end
    assign db[b]   = lvl;
    assign db_q[b] = lvl_q;
  end
  for (genvar r = 0; r < 2; r++) begin : g_rpt
    rpt_t          st, st_nx;
    logic [TW-1:0] tmr, tmr_nx;
    logic          req, req_nx;
    always_ff @(posedge i_clk or negedge rst_n)
      if (!rst_n) begin
        st  <= IDLE;
        tmr <= '0;
        req <= 1'b0;
      end else begin
        st  <= st_nx;
        tmr <= tmr_nx;
        req <= req_nx;
      end
    always_comb begin
      st_nx  = st;
      tmr_nx = tmr + TW'(1);
      req_nx = 1'b0;
      if (fall[r]) begin
        st_nx  = IDLE;
        tmr_nx = '0;
      end else if (st == IDLE) begin
        tmr_nx = '0;
        req_nx = rise[r];
        st_nx  = rise[r] ? DELAY : IDLE;
      end else if (st == DELAY) begin
        if (RPT_DELAY == 0) tmr_nx = '0;
        else if (tmr == TW'(RPT_DELAY - 1)) begin
          req_nx = 1'b1;
          st_nx  = REPEAT;
          tmr_nx = '0;
        end
      end else if (tmr == TW'(RPT_PERIOD - 1)) begin
        req_nx = 1'b1;
        tmr_nx = '0;
      end
    end
    assign rpt_req[r] = req;
  end
  for (genvar g = 0; g < LED_W; g++) begin : g_bar
    assign bar[g] = value > LED_W'(g);
  end
  // clear dominates; simultaneous up and down cancel
  always_comb begin
    value_nx = clr_req            ? '0 :
               rpt_req == 2'b01   ? ((i_mode[0] && &value) ? value : value + LED_W'(1)) :
               rpt_req == 2'b10   ? ((i_mode[0] && value == '0) ? value : value - LED_W'(1)) :
                                    value;
  end
  always_ff @(posedge i_clk or negedge rst_n)
    if (!rst_n) begin
      clr_req <= 1'b0;
      value   <= '0;
      o_step  <= 1'b0;
      o_leds  <= '0;
    end else begin
      clr_req <= rise[2];
      value   <= value_nx;
      o_step  <= value_nx != value;
      o_leds  <= i_mode[1] ? bar : value;
    end
endmodule

// File: tb/tb_button_led_ctrl.sv
// tb_button_led_ctrl: scoreboard bench; a window-based debounce model and
// arithmetic repeat schedule predict every step, value and LED pattern.
module tb_button_led_ctrl;
  localparam int LW = 4, DB = 4, RD = 10, RP = 3, MAXV = 15;
  logic clk = 0, rst_n = 1, up = 0, dn = 0, clr = 0;
  logic [1:0] mode = 0;
  logic [LW-1:0] leds, value;
  logic step;
  int total = 0, bad = 0, cyc = 0;
  typedef struct { int cyc; int val; } exp_t;
  exp_t sb[$];
  int m_val = 0, since = 0;
  int rise_e[3];
  bit m_db[3], rq[3];
  bit smp[3][DB+2];
  logic [LW-1:0] m_leds = 0;

  button_led_ctrl #(.LED_W(LW), .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_up(up), .i_btn_dn(dn), .i_btn_clr(clr),
    .i_mode(mode), .o_leds(leds), .o_value(value), .o_step(step));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bar_of(int v);
    return (1 << (v < LW ? v : LW)) - 1;
  endfunction

  // reference model: one evaluation per clock edge e = cyc+1
  always @(posedge clk or negedge rst_n) begin : model
    int e, nv, d;
    bit all_diff;
    bit [2:0] raw;
    if (!rst_n || since < 2) begin
      since = rst_n ? since + 1 : 0;
      m_val = 0;
      m_leds = 0;
      sb.delete();
      for (int b = 0; b < 3; b++) begin
        m_db[b] = 0;
        rq[b] = 0;
        for (int k = 0; k < DB + 2; k++) smp[b][k] = 0;
      end
    end else begin
      e = cyc + 1;
      nv = m_val;
      if (rq[2]) nv = 0;
      else if (rq[0] && !rq[1]) nv = mode[0] ? (m_val == MAXV ? MAXV : m_val + 1) : (m_val + 1) % (MAXV + 1);
      else if (rq[1] && !rq[0]) nv = mode[0] ? (m_val == 0 ? 0 : m_val - 1) : (m_val + MAXV) % (MAXV + 1);
      m_leds = LW'(mode[1] ? bar_of(m_val) : m_val);
      if (nv != m_val) sb.push_back('{e, nv});
      m_val = nv;
      for (int b = 0; b < 3; b++) begin
        d = e - rise_e[b];
        rq[b] = m_db[b] && (d == 1 || (b < 2 && RD > 0 && d - 1 >= RD && (d - 1 - RD) % RP == 0));
      end
      raw = {clr, dn, up};
      for (int b = 0; b < 3; b++) begin
        for (int k = DB + 1; k > 0; k--) smp[b][k] = smp[b][k-1];
        smp[b][0] = raw[b];
        all_diff = 1;
        for (int k = 2; k <= DB + 1; k++) if (smp[b][k] == m_db[b]) all_diff = 0;
        if (all_diff) begin
          m_db[b] = !m_db[b];
          if (m_db[b]) rise_e[b] = e;
        end
      end
    end
  end

  // monitor: pops the scoreboard on every o_step, checks value and LEDs each cycle
  always @(negedge clk) begin : monitor
    exp_t x;
    if (step) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL step_extra cyc=%0d got value=%0d, no step expected", cyc, value);
      end else begin
        x = sb.pop_front();
        if (x.cyc != cyc || x.val != int'(value)) begin
          bad++;
          $display("FAIL step got cyc=%0d value=%0d, expected cyc=%0d value=%0d", cyc, value, x.cyc, x.val);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      total++;
      bad++;
      x = sb.pop_front();
      $display("FAIL step_missing cyc=%0d, expected step to value=%0d at cyc=%0d", cyc, x.val, x.cyc);
    end
    total++;
    if (value !== LW'(m_val)) begin
      bad++;
      $display("FAIL value cyc=%0d got=%0d expected=%0d", cyc, value, m_val);
    end
    total++;
    if (leds !== m_leds) begin
      bad++;
      $display("FAIL leds cyc=%0d got=%b expected=%b", cyc, leds, m_leds);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic press(input bit u, input bit d, input bit c, input int hold, input int gap);
    up = u;
    dn = d;
    clr = c;
    tick(hold);
    up = 0;
    dn = 0;
    clr = 0;
    tick(gap);
  endtask

  initial begin : stim
    int e0, kind;
    #2 rst_n = 0;
    #1;
    chk("rst_value", value, 0);
    chk("rst_leds", leds, 0);
    chk("rst_step", step, 0);
    tick(3);
    rst_n = 1;
    tick(6);
    // glitch shorter than the debounce window
    press(1, 0, 0, 3, DB + 8);
    chk("glitch_value", value, 0);
    // single press latency to LEDs
    up = 1;
    e0 = cyc + 1;
    do @(negedge clk); while (cyc < e0 + DB + 3);
    chk("lat_leds_before", leds, 0);
    @(negedge clk);
    chk("lat_leds_after", leds, 1);
    chk("lat_value", value, 1);
    @(posedge clk);
    #1;
    up = 0;
    tick(DB + 8);
    chk("single_value", value, 1);
    // long hold exercising delay and repeat
    press(1, 0, 0, DB + 33, DB + 8);
    // wrap and saturate boundaries
    mode = 2'b00;
    press(0, 0, 1, 8, DB + 6);
    chk("clr_value", value, 0);
    press(0, 1, 0, 8, DB + 6);
    chk("wrap_dn", value, 15);
    mode = 2'b01;
    press(1, 0, 0, 8, DB + 6);
    chk("sat_up", value, 15);
    mode = 2'b00;
    press(1, 0, 0, 8, DB + 6);
    chk("wrap_up", value, 0);
    mode = 2'b01;
    press(0, 1, 0, 8, DB + 6);
    chk("sat_dn", value, 0);
    mode = 2'b00;
    press(1, 0, 0, 8, DB + 6);
    press(1, 1, 0, 8, DB + 6);
    chk("updn_cancel", value, 1);
    press(1, 0, 1, 8, DB + 6);
    chk("clr_up", value, 0);
    // bar display
    for (int i = 0; i < 6; i++) press(1, 0, 0, 8, DB + 6);
    mode = 2'b10;
    tick(2);
    chk("bar6", leds, 15);
    press(0, 0, 1, 8, DB + 6);
    press(1, 0, 0, 8, DB + 6);
    press(1, 0, 0, 8, DB + 6);
    chk("bar2", leds, 3);
    mode = 2'b00;
    // reset in the middle of auto-repeat, button still held afterwards
    up = 1;
    tick(DB + 18);
    rst_n = 0;
    #1;
    chk("midrst_value", value, 0);
    chk("midrst_leds", leds, 0);
    chk("midrst_step", step, 0);
    tick(3);
    rst_n = 1;
    tick(DB + 8);
    up = 0;
    tick(DB + 8);
    chk("post_rst_value", value, 1);
    // randomized presses, overlaps and mode changes
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      press(kind <= 3 || kind == 7, (kind >= 4 && kind <= 7) || kind == 9, kind >= 8,
            $urandom_range(1, 35), $urandom_range(1, 14));
    end
    tick(DB + 20);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
